mips_cpu_divideru: RTL and testbench
====================================

MIPS_CPU_DIVIDERU -- requirements
Module: mips_cpu_divideru

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous active-low reset.
REQ-004 start  input  1  sampled high in IDLE → operands latched, division begins.
REQ-005 Dividend  input  32  unsigned dividend, sampled only on the accepting edge.
REQ-006 Divisor  input  32  unsigned divisor, sampled only on the accepting edge.
REQ-007 Quotient  output  32  registered unsigned quotient.
REQ-008 Remainder  output  32  registered unsigned remainder.
REQ-009 done  output  1  registered; high = result valid.
REQ-010 dbz  output  1  registered; high = last completed operation had Divisor == 0.

Function
REQ-011 States SHALL be IDLE, BUSY and DONE; the reset state SHALL be IDLE.
REQ-012 IDLE or DONE with start=1 at a rising edge SHALL latch both operands, clear done and dbz, load the iteration counter with 32, and go to BUSY.
REQ-013 BUSY SHALL run restoring radix-2 division, one quotient bit per cycle, MSB first, with a 33-bit partial remainder (shift left, subtract divisor, restore if negative).
REQ-014 Latency: start accepted at edge N → done=1 after edge N+32, with Quotient = floor(Dividend/Divisor) and Remainder = Dividend mod Divisor on the same edge.
REQ-015 Quotient and Remainder SHALL hold the previous result until the completing edge and are never updated mid-operation.
REQ-016 DONE SHALL hold done=1 and the results until the next accepted start; no clear is needed.
REQ-017 start in BUSY SHALL be ignored, with no restart and no operand re-latch.
REQ-018 start held high across completion SHALL be accepted on the first edge in DONE, and a new operation SHALL begin.
REQ-019 Divisor == 0 SHALL complete with Quotient = 32'hFFFF_FFFF, Remainder = Dividend, dbz=1.
REQ-020 Operands SHALL be treated as full 32-bit unsigned values, including MSB set; no sign handling.
REQ-021 Dividend < Divisor SHALL give Quotient=0 and Remainder=Dividend; Dividend == Divisor SHALL give Quotient=1 and Remainder=0.

Reset
REQ-022 reset=0 SHALL immediately force, independent of clk: state=IDLE, Quotient=0, Remainder=0, done=0, dbz=0, counter=0.
REQ-023 Reset during BUSY SHALL abandon the operation; no done is produced after reset release until a new start.
REQ-024 The first accepted start after reset release SHALL behave per REQ-012.

Configuration
REQ-025 Macro MIPS_CPU_DIVIDERU_DBZ_FAST_EN: when defined, Divisor == 0 at acceptance SHALL skip BUSY, with done=1, dbz=1 and the REQ-019 results after edge N+1.
REQ-026 When MIPS_CPU_DIVIDERU_DBZ_FAST_EN is undefined, divide-by-zero SHALL run all 32 iterations (done after edge N+32), with results per REQ-019 produced naturally by the datapath and dbz=1.

Verification
REQ-027 After reset: start with 1/1 → done after 32 cycles; Quotient=1, Remainder=0, dbz=0.
REQ-028 Start with 7/2 → Quotient=3, Remainder=1; 9999/10000 → Quotient=0, Remainder=9999.
REQ-029 Start with 32'hFFFF_FFFF / 32'h0000_0010 → Quotient=32'h0FFF_FFFF, Remainder=15; also 32'h8000_0000/3 → Quotient=715827882, Remainder=2.
REQ-030 Start with 100/0 → Quotient=32'hFFFF_FFFF, Remainder=100, dbz=1; done after 1 cycle with the macro defined, 32 cycles without.
REQ-031 Start pulsed again mid-BUSY with different operands → original result returned at the original cycle; then reset=0 mid-BUSY → all outputs 0 and done never rises.
REQ-032 Random regression of 100000 ops (random 32-bit Dividend, non-zero Divisor) → Quotient == Dividend/Divisor and Remainder == Dividend%Divisor on every done.

Source files
------------

// File: rtl/mips_cpu_divideru.sv
// mips_cpu_divideru: 32-bit unsigned restoring radix-2 divider, one quotient
// bit per clock, MSB first. A started operation returns its result 32 edges
// after acceptance. Divide-by-zero yields Quotient = all ones,
// Remainder = Dividend, and dbz = 1.
// Optional build macro MIPS_CPU_DIVIDERU_DBZ_FAST_EN: a zero divisor completes
// on the first edge after acceptance instead of running all 32 iterations.
module mips_cpu_divideru (
  input  logic        clk,
  input  logic        reset,      // asynchronous, active-low
  input  logic        start,
  input  logic [31:0] Dividend,
  input  logic [31:0] Divisor,
  output logic [31:0] Quotient,
  output logic [31:0] Remainder,
  output logic        done,
  output logic        dbz
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] dvd_q;      // dividend bits shift out of the top, quotient bits shift in at the bottom
  logic [31:0] dvs_q;      // latched divisor
  logic [31:0] rem_q;      // partial remainder, always < divisor between iterations
  logic [5:0]  count_q;    // iterations still to run
  logic        accept;
  logic        finish;
  logic        fast_dbz;
  logic [32:0] rem_shift;  // 33-bit partial remainder after the left shift
  logic [32:0] diff;
  logic        q_bit;
  logic [31:0] rem_nxt;

`ifdef MIPS_CPU_DIVIDERU_DBZ_FAST_EN
  assign fast_dbz = (dvs_q == '0);
`else
  assign fast_dbz = 1'b0;
`endif

  // One restoring-division step: shift, trial subtract, keep or restore.
  always_comb begin
    rem_shift = {rem_q, dvd_q[31]};
    diff      = rem_shift - {1'b0, dvs_q};
    // A shifted remainder at or above 2^32 always exceeds the divisor;
    // otherwise bit 32 of the difference is the borrow out.
    q_bit     = rem_shift[32] | ~diff[32];
    rem_nxt   = q_bit ? diff[31:0] : rem_shift[31:0];
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and control decode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt = state;
    accept    = 1'b0;
    finish    = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (fast_dbz || count_q == 6'd1) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, iteration datapath and registered results.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: working registers are ordinary flops, so they are reset along with the outputs.
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      count_q   <= '0;
      Quotient  <= '0;
      Remainder <= '0;
      done      <= 1'b0;
      dbz       <= 1'b0;
    end else if (accept) begin
      dvd_q   <= Dividend;
      dvs_q   <= Divisor;
      rem_q   <= '0;
      count_q <= 6'd32;
      done    <= 1'b0;
      dbz     <= 1'b0;
    end else if (state == BUSY) begin
      if (finish) begin
        count_q <= '0;
        done    <= 1'b1;
        dbz     <= (dvs_q == '0);
        if (fast_dbz) begin
          // Fast path fires on the first BUSY edge, so dvd_q is still the untouched dividend.
          Quotient  <= '1;
          Remainder <= dvd_q;
        end else begin
          Quotient  <= {dvd_q[30:0], q_bit};
          Remainder <= rem_nxt;
        end
      end else begin
        dvd_q   <= {dvd_q[30:0], q_bit};
        rem_q   <= rem_nxt;
        count_q <= count_q - 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_mips_cpu_divideru.sv
// Self-checking bench for mips_cpu_divideru: table of directed divisions,
// a short random run, and hand-written multi-cycle corner sequences.
module tb_mips_cpu_divideru;

`ifdef MIPS_CPU_DIVIDERU_DBZ_FAST_EN
  localparam int DBZ_LAT = 1;
`else
  localparam int DBZ_LAT = 32;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] Dividend;
  logic [31:0] Divisor;
  logic [31:0] Quotient;
  logic [31:0] Remainder;
  logic        done;
  logic        dbz;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } vec_t;

  vec_t vecs[15];

  mips_cpu_divideru dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .done      (done),
    .dbz       (dbz)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Count rising edges until done is seen; lat = -1 if the budget expires.
  task automatic wait_done(input int budget, output int lat);
    lat = -1;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] dvd, input logic [31:0] dvs,
                        input logic [31:0] exp_q, input logic [31:0] exp_r,
                        input logic exp_dbz, input int exp_lat);
    int lat;
    @(negedge clk);
    start    = 1'b1;
    Dividend = dvd;
    Divisor  = dvs;
    @(posedge clk);
    #1;
    check({tag, " done_clear"}, {31'b0, done}, 32'd0);
    @(negedge clk);
    start    = 1'b0;
    Dividend = $urandom;
    Divisor  = $urandom;
    wait_done(40, lat);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " quotient"}, Quotient, exp_q);
    check({tag, " remainder"}, Remainder, exp_r);
    check({tag, " dbz"}, {31'b0, dbz}, {31'b0, exp_dbz});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [31:0] a, b;

    vecs[0]  = '{32'd1,          32'd1,          32'd1,          32'd0,          1'b0};
    vecs[1]  = '{32'd7,          32'd2,          32'd3,          32'd1,          1'b0};
    vecs[2]  = '{32'd9999,       32'd10000,      32'd0,          32'd9999,       1'b0};
    vecs[3]  = '{32'hFFFF_FFFF,  32'h0000_0010,  32'h0FFF_FFFF,  32'd15,         1'b0};
    vecs[4]  = '{32'h8000_0000,  32'd3,          32'd715827882,  32'd2,          1'b0};
    vecs[5]  = '{32'd100,        32'd0,          32'hFFFF_FFFF,  32'd100,        1'b1};
    vecs[6]  = '{32'd5,          32'd5,          32'd1,          32'd0,          1'b0};
    vecs[7]  = '{32'd0,          32'd7,          32'd0,          32'd0,          1'b0};
    vecs[8]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0};
    vecs[9]  = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
    vecs[10] = '{32'h1234_5678,  32'h8000_0000,  32'd0,          32'h1234_5678,  1'b0};
    vecs[11] = '{32'hFFFF_FFFE,  32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFE,  1'b0};
    vecs[12] = '{32'h8000_0000,  32'd0,          32'hFFFF_FFFF,  32'h8000_0000,  1'b1};
    vecs[13] = '{32'd1000000,    32'd7,          32'd142857,     32'd1,          1'b0};
    vecs[14] = '{32'hFFFF_FFFF,  32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b0};

    // Reset state, including a start pulse while reset is held.
    reset    = 1'b0;
    start    = 1'b0;
    Dividend = 32'd0;
    Divisor  = 32'd0;
    #1;
    check("rst quotient", Quotient, 32'd0);
    check("rst remainder", Remainder, 32'd0);
    check("rst done", {31'b0, done}, 32'd0);
    check("rst dbz", {31'b0, dbz}, 32'd0);
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst start_ignored", {31'b0, done}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    reset = 1'b1;

    // Directed table.
    for (int i = 0; i < 15; i++)
      run_op($sformatf("vec%0d", i), vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].r,
             vecs[i].dbz, (vecs[i].dvs == 32'd0) ? DBZ_LAT : 32);

    // Short random run with non-zero divisors.
    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      b = (i % 2 == 0) ? $urandom : $urandom_range(1, 1000);
      if (b == 32'd0) b = 32'd1;
      run_op($sformatf("rnd%0d", i), a, b, a / b, a % b, 1'b0, 32);
    end

    // Start pulsed mid-BUSY is ignored; results hold until completion.
    run_op("pre", 32'd1000000, 32'd7, 32'd142857, 32'd1, 1'b0, 32);
    @(negedge clk);
    start = 1'b1; Dividend = 32'd100; Divisor = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    start = 1'b1; Dividend = 32'd50; Divisor = 32'd3;
    @(posedge clk);
    #1;
    check("busy quotient_held", Quotient, 32'd142857);
    check("busy remainder_held", Remainder, 32'd1);
    check("busy done_low", {31'b0, done}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    wait_done(40, lat);
    check("busy latency", lat, 32'd22);
    check("busy quotient", Quotient, 32'd14);
    check("busy remainder", Remainder, 32'd2);

    // Start held high across completion is re-accepted on the first DONE edge.
    @(negedge clk);
    start = 1'b1; Dividend = 32'd1000; Divisor = 32'd10;
    @(posedge clk);
    @(negedge clk);
    Dividend = 32'd77; Divisor = 32'd7;
    wait_done(40, lat);
    check("held latency", lat, 32'd32);
    check("held quotient", Quotient, 32'd100);
    check("held remainder", Remainder, 32'd0);
    @(posedge clk);
    #1;
    check("held reaccept", {31'b0, done}, 32'd0);
    check("held quotient_kept", Quotient, 32'd100);
    @(negedge clk);
    start = 1'b0;
    wait_done(40, lat);
    check("held2 latency", lat, 32'd32);
    check("held2 quotient", Quotient, 32'd11);
    check("held2 remainder", Remainder, 32'd0);

    // Reset mid-BUSY abandons the operation.
    @(negedge clk);
    start = 1'b1; Dividend = 32'hFFFF_FFFF; Divisor = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("midrst quotient", Quotient, 32'd0);
    check("midrst remainder", Remainder, 32'd0);
    check("midrst done", {31'b0, done}, 32'd0);
    check("midrst dbz", {31'b0, dbz}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    wait_done(40, lat);
    check("midrst no_done", lat, -1);
    run_op("postrst", 32'd1, 32'd1, 32'd1, 32'd0, 1'b0, 32);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
